piso_tx: RTL and testbench
==========================

Name: piso_tx

Overview:
- Parallel-in, serial-out transmitter with a valid/ready load handshake and a shift-enable input.
- Accepts a WIDTH-bit word and drives it out one bit per enabled clock on a single registered line, with a framing valid flag and an end-of-word pulse.
- Serves as the driving end of a serial link whose far end samples the line with flip-flops clocked on the same clk.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word to transmit.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  block can accept a word this cycle.
- shift_en  input  1  bit-rate strobe; a bit advances only on edges where shift_en=1.
- sout  output  1  serial data; registered.
- sout_valid  output  1  sout carries a frame bit; registered.
- last  output  1  high while the final bit of the word is on sout; registered.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst_n=0, async, regardless of clk):
  - State goes to IDLE.
  - sout=0, sout_valid=0, last=0, busy=0.
  - Shift register and bit counter are cleared.
  - din_ready=0 while rst_n=0, and 1 from the first cycle after release.
- States: IDLE, SHIFT.
- IDLE:
  - din_ready=1 (combinational: state==IDLE and rst_n=1).
  - sout=0, sout_valid=0.
  - Handshake occurs on a rising edge with din_valid=1 and din_ready=1. On that edge:
    - din is captured.
    - The first bit (din[WIDTH-1] if MSB_FIRST, else din[0]) is registered onto sout.
    - sout_valid goes to 1, the counter goes to 0, and state goes to SHIFT.
  - Latency: the first bit is visible the cycle after the handshake edge, independent of shift_en.
- SHIFT:
  - din_ready=0; din and din_valid are ignored.
  - On an edge with shift_en=1 and counter<WIDTH-1:
    - The next bit moves to sout.
    - The counter increments.
    - last goes to 1 when the counter becomes WIDTH-1.
  - On an edge with shift_en=1 and counter==WIDTH-1:
    - sout=0, sout_valid=0, last=0.
    - State goes to IDLE.
  - On an edge with shift_en=0, all outputs and state hold. Bit k therefore stays on sout until the enabled edge that advances it.
  - Each bit is held for at least one cycle. With shift_en tied high, each bit lasts exactly one cycle, and a word occupies WIDTH cycles of sout_valid.
- Back-to-back words:
  - After the final enabled edge there is at least one IDLE cycle, so a second word is accepted no earlier than 1 cycle after sout_valid falls.
  - The minimum period with shift_en=1 is WIDTH+1 cycles per word.
- Counter width is clog2(WIDTH); the counter does not wrap within a word.
- Mid-word reset: rst_n low during SHIFT aborts the word immediately (async). Outputs reach reset values without waiting for clk. No partial-word resumption.
- din changing after the handshake has no effect on the word in flight.
- busy == (state==SHIFT); busy equals sout_valid in every cycle.

Test Plan:
- WIDTH=8, MSB_FIRST=1, shift_en=1, din=8'hA5, one-cycle handshake:
  - sout = 1,0,1,0,0,1,0,1 on 8 consecutive cycles.
  - sout_valid high for exactly those 8 cycles; last high on the 8th only.
  - din_ready returns to 1 the cycle after.
- MSB_FIRST=0, din=8'h01, shift_en=1 -> sout = 1,0,0,0,0,0,0,0; last on cycle 8.
- shift_en pattern 1,0,0,1,... with din=8'hF0, MSB first:
  - Each bit is held 3 cycles; sequence 1,1,1,1,0,0,0,0 with 24 cycles of sout_valid.
  - din_valid pulses during SHIFT are ignored (din_ready=0).
- Two words 8'h3C then 8'hC3 with din_valid held high and shift_en=1:
  - Second word starts exactly 1 idle cycle after the first; total 17 cycles from the first handshake to the end of the second.
  - Bit streams match 00111100 then 11000011.
- rst_n pulled low asynchronously mid-cycle after the 4th bit of 8'hFF:
  - sout, sout_valid, last and busy drop to 0 before the next clk edge.
  - After release, din_ready=1 and a new word 8'h81 transmits cleanly as 1,0,0,0,0,0,0,1.
- Power-up with rst_n=0 for 3 cycles, din_valid=1 -> no handshake and all outputs 0. The first handshake happens on the first edge after rst_n rises.

Source files
------------

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with valid/ready load and shift-enable pacing
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_END = CW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] shreg_q, load_d, shift_d;
  logic [CW-1:0]    cnt_q;
  logic             sout_q, valid_q, last_q, first_d, next_d;
  // Bit order is resolved here; the shift register always holds only the bits still to be sent
  always_comb begin
    first_d = MSB_FIRST ? din[WIDTH-1] : din[0];
    next_d  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    load_d  = MSB_FIRST ? din << 1 : din >> 1;
    shift_d = MSB_FIRST ? shreg_q << 1 : shreg_q >> 1;
  end
  // Framing FSM: load on handshake, advance one bit per enabled edge, idle one cycle between words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      sout_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      if (din_valid) begin
        state_q <= SHIFT;
        shreg_q <= load_d;
        cnt_q   <= '0;
        sout_q  <= first_d;
        valid_q <= 1'b1;
        last_q  <= 1'b0;
      end
    end else if (shift_en) begin
      if (cnt_q == CNT_END) begin
        state_q <= IDLE;
        sout_q  <= 1'b0;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        shreg_q <= shift_d;
        cnt_q   <= cnt_q + CW'(1);
        sout_q  <= next_d;
        last_q  <= (cnt_q == CNT_END - CW'(1));
      end
    end
  end
  assign din_ready  = (state_q == IDLE) && rst_n;
  assign busy       = (state_q == SHIFT);
  assign sout       = sout_q;
  assign sout_valid = valid_q;
  assign last       = last_q;
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed checks of piso_tx in both bit orders driven from shared stimulus
module tb_piso_tx;
  logic       clk = 1'b0;
  logic       rst_n, din_valid, shift_en;
  logic [7:0] din;
  logic       rdy_m, sout_m, sv_m, last_m, busy_m;
  logic       rdy_l, sout_l, sv_l, last_l, busy_l;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
    .shift_en(shift_en), .sout(sout_m), .sout_valid(sv_m), .last(last_m), .busy(busy_m)
  );
  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
    .shift_en(shift_en), .sout(sout_l), .sout_valid(sv_l), .last(last_l), .busy(busy_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic rdy);
    chk({tag, " sout_m"}, {31'd0, sout_m}, 32'd0);
    chk({tag, " sv_m"}, {31'd0, sv_m}, 32'd0);
    chk({tag, " last_m"}, {31'd0, last_m}, 32'd0);
    chk({tag, " busy_m"}, {31'd0, busy_m}, 32'd0);
    chk({tag, " rdy_m"}, {31'd0, rdy_m}, {31'd0, rdy});
    chk({tag, " sout_l"}, {31'd0, sout_l}, 32'd0);
    chk({tag, " sv_l"}, {31'd0, sv_l}, 32'd0);
    chk({tag, " busy_l"}, {31'd0, busy_l}, 32'd0);
    chk({tag, " rdy_l"}, {31'd0, rdy_l}, {31'd0, rdy});
  endtask

  // Called the cycle after the handshake edge; dv_mode 0=low, 1=pulses, 2=held high during the word
  task automatic run_word(input string tag, input logic [7:0] w, input int hold, input int dv_mode);
    for (int k = 0; k < 8; k++) begin
      for (int h = 0; h < hold; h++) begin
        chk({tag, " sout_m"}, {31'd0, sout_m}, {31'd0, w[7-k]});
        chk({tag, " sout_l"}, {31'd0, sout_l}, {31'd0, w[k]});
        chk({tag, " sv_m"}, {31'd0, sv_m}, 32'd1);
        chk({tag, " sv_l"}, {31'd0, sv_l}, 32'd1);
        chk({tag, " last_m"}, {31'd0, last_m}, (k == 7) ? 32'd1 : 32'd0);
        chk({tag, " last_l"}, {31'd0, last_l}, (k == 7) ? 32'd1 : 32'd0);
        chk({tag, " busy_m"}, {31'd0, busy_m}, 32'd1);
        chk({tag, " rdy_m"}, {31'd0, rdy_m}, 32'd0);
        shift_en  = (h == hold - 1);
        din_valid = (dv_mode == 2) || (dv_mode == 1 && h == 1);
        tick;
      end
    end
    chk_idle({tag, " end"}, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    din = 8'hA5;
    din_valid = 1'b1;
    shift_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_idle("por", 1'b0);
    end
    rst_n = 1'b1;
    #1;
    chk("rdy after release", {31'd0, rdy_m}, 32'd1);
    tick;
    din = 8'h5A;
    run_word("a5", 8'hA5, 1, 0);
    din = 8'h01;
    din_valid = 1'b1;
    tick;
    din = 8'hFF;
    run_word("01", 8'h01, 1, 0);
    din = 8'hF0;
    din_valid = 1'b1;
    shift_en = 1'b0;
    tick;
    din = 8'h0F;
    run_word("f0 hold3", 8'hF0, 3, 1);
    din = 8'h3C;
    din_valid = 1'b1;
    shift_en = 1'b1;
    tick;
    din = 8'hC3;
    run_word("3c", 8'h3C, 1, 2);
    tick;
    din = 8'h00;
    run_word("c3", 8'hC3, 1, 2);
    din_valid = 1'b0;
    tick;
    chk_idle("gap", 1'b1);
    din = 8'hFF;
    din_valid = 1'b1;
    tick;
    din_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("ff sout_m", {31'd0, sout_m}, 32'd1);
      chk("ff sv_m", {31'd0, sv_m}, 32'd1);
      if (k < 3) tick;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async rst", 1'b0);
    tick;
    chk_idle("rst held", 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rdy after abort", {31'd0, rdy_m}, 32'd1);
    din = 8'h81;
    din_valid = 1'b1;
    tick;
    din_valid = 1'b0;
    run_word("81", 8'h81, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
